sram_zbt_pipe_ctrl: RTL and testbench

//  Parametrised pipelined (ZBT-style) synchronous SRAM controller with a divided SRAM clock.

---
 rtl/sram_zbt_pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_zbt_pipe_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_zbt_pipe_ctrl.sv
// Pipelined ZBT-style SRAM controller: one request per divided sram_clk period, fixed-latency tagged reads.
// Build option SRAM_BW_EN adds the req_bw port and drives per-lane byte-write enables from it.
module sram_zbt_pipe_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 18,
  parameter int BW_W    = 2,
  parameter int CLK_DIV = 4,
  parameter int RD_LAT  = 2,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
`ifdef SRAM_BW_EN
  input  logic [BW_W-1:0]   req_bw,
`endif
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              sram_clk,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_we_n,
  output logic [2:0]        sram_ce,
  output logic [BW_W-1:0]   sram_bw_n,
  output logic              sram_oe_n,
  output logic              sram_adv_ld,
  output logic              sram_cke_n
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] SAMP = CW'(CLK_DIV / 2 - 1);

  typedef struct packed {
    logic              vld;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  logic [CW-1:0]   div_cnt;
  logic            launch;
  logic            accept;
  logic            rd_cap;
  logic [BW_W-1:0] wr_bw_n;
  stage_t          pipe [RD_LAT];
  stage_t          ph;

  assign launch      = (div_cnt == LAST);
  assign accept      = launch && req_valid;
  assign req_ready   = launch;
  assign sram_clk    = (div_cnt >= HALF);
  assign sram_oe_n   = 1'b0;
  assign sram_adv_ld = 1'b0;
  assign sram_cke_n  = 1'b0;

`ifdef SRAM_BW_EN
  assign wr_bw_n = ~req_bw;
`else
  assign wr_bw_n = '0;
`endif

  // ph is the request whose data phase occupies the current sram period
  assign sram_data = (ph.vld && ph.we) ? ph.wdata : {DATA_W{1'bz}};
  assign rd_cap    = (div_cnt == SAMP) && ph.vld && !ph.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_ce   <= 3'b101;
      sram_bw_n <= '1;
    end else if (launch) begin
      if (accept) begin
        sram_addr <= req_addr;
        sram_we_n <= ~req_we;
        sram_ce   <= 3'b010;
        sram_bw_n <= req_we ? wr_bw_n : '1;
      end else begin
        sram_we_n <= 1'b1;
        sram_ce   <= 3'b101;
        sram_bw_n <= '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      ph <= '0;
    end else if (launch) begin
      pipe[0] <= '{vld: accept, we: req_we, wdata: req_wdata, tag: req_tag};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      ph <= pipe[RD_LAT-1];
    end
  end

  // Read data is captured on the sram_clk rising edge inside the data period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_tag   <= '0;
    end else begin
      rd_valid <= rd_cap;
      if (rd_cap) begin
        rd_data <= sram_data;
        rd_tag  <= ph.tag;
      end
    end
  end

endmodule

// File: tb/tb_sram_zbt_pipe_ctrl.sv
// Bench for sram_zbt_pipe_ctrl: ZBT SRAM behavioural model on the pins plus a request-level scoreboard.
module tb_sram_zbt_pipe_ctrl;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 18;
  localparam int BW_W     = 2;
  localparam int CLK_DIV  = 4;
  localparam int RD_LAT   = 2;
  localparam int TAG_W    = 4;
  localparam int LANE_W   = DATA_W / BW_W;
  localparam int RLAT_CYC = CLK_DIV / 2 + RD_LAT * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [BW_W-1:0]   req_bw = '1;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              sram_clk;
  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_data;
  logic              sram_we_n;
  logic [2:0]        sram_ce;
  logic [BW_W-1:0]   sram_bw_n;
  logic              sram_oe_n, sram_adv_ld, sram_cke_n;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  sram_zbt_pipe_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BW_W(BW_W),
    .CLK_DIV(CLK_DIV), .RD_LAT(RD_LAT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
`ifdef SRAM_BW_EN
    .req_bw(req_bw),
`endif
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .sram_clk(sram_clk), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_we_n(sram_we_n), .sram_ce(sram_ce), .sram_bw_n(sram_bw_n),
    .sram_oe_n(sram_oe_n), .sram_adv_ld(sram_adv_ld), .sram_cke_n(sram_cke_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [BW_W-1:0] en);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < DATA_W; b++) if (en[b / LANE_W]) r[b] = new_v[b];
    return r;
  endfunction

  // ---------------- ZBT SRAM pin model ----------------
  typedef struct {
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [BW_W-1:0]   bwn;
  } cmd_t;

  cmd_t              cq[$];
  cmd_t              wr_cmd, cur;
  logic              wr_pend = 1'b0;
  logic              mdl_drv = 1'b0;
  logic [DATA_W-1:0] mdl_dat = '0;
  logic [DATA_W-1:0] sram_mem [int];

  assign sram_data = mdl_drv ? mdl_dat : {DATA_W{1'bz}};

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : '0;
  endfunction

  always @(posedge sram_clk) begin
    if (wr_pend) begin
      sram_mem[int'(wr_cmd.a)] = merge(mem_rd(wr_cmd.a), sram_data, ~wr_cmd.bwn);
      wr_pend = 1'b0;
    end
    cq.push_back('{sel: (sram_ce == 3'b010), we: ~sram_we_n, a: sram_addr, bwn: sram_bw_n});
  end

  // Data phase of a command spans the sram period starting RD_LAT rising edges later
  always @(negedge sram_clk) begin
    mdl_drv = 1'b0;
    if (cq.size() >= RD_LAT) begin
      cur = cq.pop_front();
      if (cur.sel && cur.we) begin
        wr_pend = 1'b1;
        wr_cmd  = cur;
      end else if (cur.sel) begin
        mdl_dat = mem_rd(cur.a);
        mdl_drv = 1'b1;
      end
    end
  end

  always @(negedge rst_n) begin
    cq.delete();
    mdl_drv = 1'b0;
    wr_pend = 1'b0;
  end

  // ---------------- request-level reference ----------------
  typedef struct {
    int                t;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] dat;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              got;
  logic [DATA_W-1:0] ref_mem [int];

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL rd_unexpected: rd_valid=1 at cycle %0d, required no return", cyc);
      end else begin
        got = exp_q.pop_front();
        if (got.t != cyc || rd_data !== got.dat || rd_tag !== got.tag) begin
          errs++;
          $display("FAIL rd_return: cycle %0d data %h tag %0d, required cycle %0d data %h tag %0d",
                   cyc, rd_data, rd_tag, got.t, got.dat, got.tag);
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].t) begin
      checks++;
      errs++;
      got = exp_q.pop_front();
      $display("FAIL rd_missing: no rd_valid by cycle %0d, required at cycle %0d tag %0d", cyc, got.t, got.tag);
    end
  end

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [TAG_W-1:0] tg, input logic [BW_W-1:0] bw, output int t_acc);
    int n;
    logic [BW_W-1:0] en;
    n = 0;
    while (req_ready !== 1'b1 && n < 2 * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errs++;
      $display("FAIL issue_ready: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_tag = tg;
`ifdef SRAM_BW_EN
    req_bw = bw;
    en = bw;
`else
    en = bw | {BW_W{1'b1}};
`endif
    t_acc = cyc + 1;
    if (we) ref_mem[int'(a)] = merge(ref_rd(a), d, en);
    else exp_q.push_back('{t: t_acc + RLAT_CYC, tag: tg, dat: ref_rd(a)});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int k;
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || rd_tag !== '0 ||
        sram_clk !== 1'b0 || sram_addr !== '0 || sram_we_n !== 1'b1 || sram_ce !== 3'b101 ||
        sram_bw_n !== 2'b11 || sram_oe_n !== 1'b0 || sram_adv_ld !== 1'b0 || sram_cke_n !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: ready=%b rd_valid=%b rd_data=%h addr=%h we_n=%b ce=%b bw_n=%b, required 0 0 0 0 1 101 11",
               req_ready, rd_valid, rd_data, sram_addr, sram_we_n, sram_ce, sram_bw_n);
    end
    rst_n = 1'b1;
    for (k = 0; k < 13; k++) begin
      req_addr = ADDR_W'(20'h00100 + k);
      req_tag  = TAG_W'(k);
      checks++;
      if (req_ready !== ((k % 4) == 3)) begin
        errs++;
        $display("FAIL ready_cadence: %0d cycles after release req_ready=%b, required %b", k, req_ready, (k % 4) == 3);
      end
      if (k < 4) begin
        checks++;
        if (sram_ce !== 3'b101 || sram_we_n !== 1'b1) begin
          errs++;
          $display("FAIL ce_before_accept: cycle %0d ce=%b we_n=%b, required 101 1", k, sram_ce, sram_we_n);
        end
      end
      if (req_ready === 1'b1)
        exp_q.push_back('{t: cyc + 1 + RLAT_CYC, tag: req_tag, dat: ref_rd(req_addr)});
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_write_timing();
    int t;
    logic [DATA_W-1:0] d;
    d = 18'h2AAAA;
    issue(1'b1, 20'h00010, d, '0, 2'b11, t);
    checks++;
    if (sram_addr !== 20'h00010 || sram_we_n !== 1'b0 || sram_ce !== 3'b010 || sram_bw_n !== 2'b00) begin
      errs++;
      $display("FAIL write_launch: addr=%h we_n=%b ce=%b bw_n=%b, required 00010 0 010 00",
               sram_addr, sram_we_n, sram_ce, sram_bw_n);
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (k >= 8 && k < 12) begin
        if (sram_data !== d) begin
          errs++;
          $display("FAIL wdata_window: t+%0d sram_data=%h, required %h", k, sram_data, d);
        end
      end else if (sram_data === d) begin
        errs++;
        $display("FAIL wdata_outside: t+%0d sram_data=%h, required released bus", k, sram_data);
      end
      if (k == 4) begin
        checks++;
        if (sram_ce !== 3'b101 || sram_we_n !== 1'b1 || sram_addr !== 20'h00010 || sram_bw_n !== 2'b11) begin
          errs++;
          $display("FAIL nop_launch: ce=%b we_n=%b addr=%h bw_n=%b, required 101 1 00010 11",
                   sram_ce, sram_we_n, sram_addr, sram_bw_n);
        end
      end
    end
  endtask

  task automatic test_read_latency();
    int t, n;
    issue(1'b0, 20'h00010, '0, 4'd5, 2'b11, t);
    checks++;
    if (sram_we_n !== 1'b1 || sram_ce !== 3'b010 || sram_bw_n !== 2'b11) begin
      errs++;
      $display("FAIL read_launch: we_n=%b ce=%b bw_n=%b, required 1 010 11", sram_we_n, sram_ce, sram_bw_n);
    end
    n = 0;
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        n++;
        checks++;
        if (k != 10 || rd_data !== 18'h2AAAA || rd_tag !== 4'd5) begin
          errs++;
          $display("FAIL read_pulse: t+%0d data=%h tag=%0d, required t+10 data=2aaaa tag=5", k, rd_data, rd_tag);
        end
      end
      if (k == 13) begin
        checks++;
        if (rd_data !== 18'h2AAAA || rd_tag !== 4'd5) begin
          errs++;
          $display("FAIL read_hold: data=%h tag=%0d, required 2aaaa 5", rd_data, rd_tag);
        end
      end
    end
    checks++;
    if (n != 1) begin
      errs++;
      $display("FAIL read_pulse_count: %0d pulses, required 1", n);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    logic [ADDR_W-1:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = ADDR_W'(20'h01000 + 37 * i + int'($urandom_range(0, 30)));
    for (int i = 0; i < 16; i++)
      issue(1'((i % 2) == 0), a[(i / 2) % 4], DATA_W'($urandom), TAG_W'(i), 2'b11, t);
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0) repeat (CLK_DIV) @(negedge clk);
      issue(1'($urandom_range(0, 1)), a[$urandom_range(0, 3)], DATA_W'($urandom),
            TAG_W'($urandom), 2'b11, t);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int tw, tr, n;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    d = 18'h15A5A;
    a = 20'h0FF00;
    issue(1'b1, a, d, '0, 2'b11, tw);
    issue(1'b0, a, '0, 4'h9, 2'b11, tr);
    n = 0;
    while (cyc < tr + 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sram_data !== d) begin
      errs++;
      $display("FAIL pre_reset_wdata: sram_data=%h, required %h", sram_data, d);
    end
    rst_n = 1'b0;
    exp_q.delete();
    ref_mem.delete(int'(a));
    #1;
    checks++;
    if (sram_data === d || sram_we_n !== 1'b1 || sram_ce !== 3'b101 || rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_immediate: sram_data=%h we_n=%b ce=%b rd_valid=%b, required released 1 101 0",
               sram_data, sram_we_n, sram_ce, rd_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (rd_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errs++;
      $display("FAIL dropped_read: %0d rd_valid pulses after reset, required 0", n);
    end
  endtask

`ifdef SRAM_BW_EN
  task automatic test_byte_write();
    int t;
    issue(1'b1, 20'h00000, '0, '0, 2'b11, t);
    issue(1'b1, 20'h00000, 18'h3FFFF, '0, 2'b01, t);
    checks++;
    if (sram_bw_n !== 2'b10) begin
      errs++;
      $display("FAIL bw_write: sram_bw_n=%b, required 10", sram_bw_n);
    end
    issue(1'b0, 20'h00000, '0, 4'hC, 2'b01, t);
    checks++;
    if (sram_bw_n !== 2'b11) begin
      errs++;
      $display("FAIL bw_read: sram_bw_n=%b, required 11", sram_bw_n);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sram_bw_n !== 2'b11 || sram_ce !== 3'b101) begin
      errs++;
      $display("FAIL bw_nop: sram_bw_n=%b ce=%b, required 11 101", sram_bw_n, sram_ce);
    end
    while (cyc < t + RLAT_CYC) @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 18'h001FF) begin
      errs++;
      $display("FAIL bw_readback: rd_valid=%b data=%h, required 1 001ff", rd_valid, rd_data);
    end
    drain();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_timing();
    test_read_latency();
    drain();
    test_back_to_back();
    test_reset_midflight();
`ifdef SRAM_BW_EN
    test_byte_write();
`endif
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
